// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide sequencer owning HI/LO; optional flush port via MD_FLUSH_EN
// Results are computed at start and held in pending regs until the modelled latency expires.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [31:0]      pendHi;
    logic [31:0]      pendLo;
    logic             pendWrite;

    logic kill;
`ifdef MD_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    logic opMult;
    logic opDiv;
    logic opMthi;
    logic opMtlo;
    logic isSigned;

    assign opMult   = (md_op[2:1] == 2'b00);
    assign opDiv    = (md_op[2:1] == 2'b01);
    assign opMthi   = (md_op == 3'b100);
    assign opMtlo   = (md_op == 3'b101);
    assign isSigned = ~md_op[0];

    logic signed [63:0] sProd;
    logic        [63:0] uProd;
    logic        [63:0] prod;

    assign sProd = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign uProd = {32'd0, src_a} * {32'd0, src_b};
    assign prod  = isSigned ? sProd : uProd;

    // Signed divide runs on magnitudes, then restores signs: quotient truncates
    // toward zero, remainder follows the dividend. 0x80000000/-1 wraps to 0x80000000.
    logic        negA;
    logic        negB;
    logic        divByZero;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] safeB;
    logic [31:0] uQuo;
    logic [31:0] uRem;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        negA      = isSigned & src_a[31];
        negB      = isSigned & src_b[31];
        divByZero = (src_b == 32'd0);
        absA      = negA ? (32'd0 - src_a) : src_a;
        absB      = negB ? (32'd0 - src_b) : src_b;
        safeB     = divByZero ? 32'd1 : absB;
        uQuo      = absA / safeB;
        uRem      = absA % safeB;
        quo       = (negA ^ negB) ? (32'd0 - uQuo) : uQuo;
        rem       = negA ? (32'd0 - uRem) : uRem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendWrite <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        if (opMult) begin
                            pendHi    <= prod[63:32];
                            pendLo    <= prod[31:0];
                            pendWrite <= 1'b1;
                            count     <= MULT_LOAD;
                            state     <= MUL;
                        end else if (opDiv) begin
                            pendHi    <= rem;
                            pendLo    <= quo;
                            pendWrite <= ~divByZero;
                            count     <= DIV_LOAD;
                            state     <= DIV;
                        end else if (opMthi) begin
                            hi <= src_a;
                        end else if (opMtlo) begin
                            lo <= src_a;
                        end
                    end
                end
                MUL, DIV: begin
                    // Flush wins over completion, so a killed result never reaches HI/LO.
                    if (kill) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == CNT_ONE) begin
                        if (pendWrite) begin
                            hi <= pendHi;
                            lo <= pendLo;
                        end
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    property noStartWhileBusy;
        @(posedge clk) disable iff (!reset) !(start && busy);
    endproperty
    assert property (noStartWhileBusy)
        else $error("md_ctrl: start asserted while busy");

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - self-checking bench for md_ctrl; flush sequences built with MD_FLUSH_EN
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int nTests = 0;
    int nFail  = 0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
`ifdef MD_FLUSH_EN
        .flush (flush),
`endif
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          expCyc;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge where busy reads 0.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output bit held);
        logic [31:0] preHi;
        logic [31:0] preLo;
        preHi = hi;
        preLo = lo;
        md_op = op;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        held  = 1'b1;
        while (busy && cyc < 60) begin
            cyc++;
            if (hi !== preHi || lo !== preLo) held = 1'b0;
            @(negedge clk);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] mHi, inout logic [31:0] mLo, output int cyc);
        longint      sp;
        logic [63:0] up;
        longint      q;
        longint      r;
        cyc = 0;
        case (op)
            3'd0: begin
                sp  = longint'(int'(a)) * longint'(int'(b));
                up  = 64'(sp);
                mHi = up[63:32];
                mLo = up[31:0];
                cyc = 5;
            end
            3'd1: begin
                up  = {32'd0, a} * {32'd0, b};
                mHi = up[63:32];
                mLo = up[31:0];
                cyc = 5;
            end
            3'd2: begin
                if (b != 0) begin
                    q   = longint'(int'(a)) / longint'(int'(b));
                    r   = longint'(int'(a)) % longint'(int'(b));
                    mLo = 32'(q);
                    mHi = 32'(r);
                end
                cyc = 10;
            end
            3'd3: begin
                if (b != 0) begin
                    mLo = a / b;
                    mHi = a % b;
                end
                cyc = 10;
            end
            3'd4: mHi = a;
            3'd5: mLo = a;
            default: ;
        endcase
    endtask

    initial begin
        int          cyc;
        bit          held;
        int          expCyc;
        logic [31:0] mHi;
        logic [31:0] mLo;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{"mult",      3'd0, 32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{"multu",     3'd1, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{"div",       3'd2, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"divu_by0",  3'd3, 32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{"mthi",      3'd4, 32'h12345678, 32'h00000000, 0,  32'h12345678, 32'hFFFFFFFD};
        vecs[5] = '{"mtlo",      3'd5, 32'h9ABCDEF0, 32'h00000000, 0,  32'h12345678, 32'h9ABCDEF0};
        vecs[6] = '{"div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[7] = '{"reserved",  3'd6, 32'hDEADBEEF, 32'h00000003, 0,  32'h00000000, 32'h80000000};

        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, cyc, held);
            check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].expCyc));
            check({vecs[i].name, "_hi"}, hi, vecs[i].expHi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].expLo);
            check({vecs[i].name, "_held"}, {31'd0, held}, 32'd1);
        end

        mHi = vecs[7].expHi;
        mLo = vecs[7].expLo;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            model(op, a, b, mHi, mLo, expCyc);
            runOp(op, a, b, cyc, held);
            check($sformatf("rand%0d_op%0d_cycles", i, op), 32'(cyc), 32'(expCyc));
            check($sformatf("rand%0d_op%0d_hi", i, op), hi, mHi);
            check($sformatf("rand%0d_op%0d_lo", i, op), lo, mLo);
            check($sformatf("rand%0d_op%0d_held", i, op), {31'd0, held}, 32'd1);
        end

`ifdef MD_FLUSH_EN
        runOp(3'd4, 32'h0000AAAA, 32'd0, cyc, held);
        runOp(3'd5, 32'h0000BBBB, 32'd0, cyc, held);
        md_op = 3'd0; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_mid_busy", {31'd0, busy}, 32'd0);
        check("flush_mid_hi", hi, 32'h0000AAAA);
        check("flush_mid_lo", lo, 32'h0000BBBB);

        md_op = 3'd0; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_last_prebusy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_last_busy", {31'd0, busy}, 32'd0);
        check("flush_last_hi", hi, 32'h0000AAAA);
        check("flush_last_lo", lo, 32'h0000BBBB);

        md_op = 3'd4; src_a = 32'h00001111; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_mthi_hi", hi, 32'h0000AAAA);
        check("flush_mthi_busy", {31'd0, busy}, 32'd0);
`endif

        runOp(3'd4, 32'h00000055, 32'd0, cyc, held);
        check("pre_rst_hi", hi, 32'h00000055);
        md_op = 3'd2; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_div_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
Sequencer for the multiply/divide resource in the MIPS pipeline.
- Accepts one operation per start pulse from the E stage.
- Models multi-cycle mult/div latency with a down-counter and owns the architectural HI/LO registers.
- Drives the busy signal that the hazard unit combines with startE to stall mfhi/mflo/mthi/mtlo/mult/div in D.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  E-stage request strobe, one cycle per operation
md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved
src_a  input  32  rs operand (forwarded)
src_b  input  32  rt operand (forwarded)
flush  input  1  exception kill (present only with MD_FLUSH_EN)
busy  output  1  operation in progress
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, busy=0, hi=0, lo=0, pending result regs=0.
- States: IDLE, MUL, DIV.
- IDLE, start=1, md_op mult/multu:
  - Latch 64-bit product (signed or unsigned) into pending regs.
  - count<=MULT_CYCLES, busy<=1, go MUL.
- IDLE, start=1, md_op div/divu:
  - Latch quotient→pending lo and remainder→pending hi.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - count<=DIV_CYCLES, busy<=1, go DIV.
- IDLE, start=1, mthi: hi<=src_a at that edge. busy stays 0; state stays IDLE.
- IDLE, start=1, mtlo: lo<=src_a at that edge. busy stays 0; state stays IDLE.
- MUL/DIV: count decrements each cycle. On the edge where count==1:
  - hi/lo<=pending.
  - busy<=0, return IDLE.
  - The new hi/lo are visible the same cycle busy reads 0.
- Latency: start at edge N → busy high for exactly MULT_CYCLES/DIV_CYCLES cycles → hi/lo updated at edge N+MULT_CYCLES / N+DIV_CYCLES.
- Divide by zero (src_b==0, div/divu):
  - Full DIV_CYCLES busy period runs.
  - hi/lo remain unchanged at completion.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- start while busy: ignored. The hazard unit guarantees this never happens; an assertion flags it in simulation.
- Reserved md_op with start: no effect.
- hi/lo only change at completion or on mthi/mtlo. They hold during busy, so a stalled reader sees the old values until busy falls.
- Reset mid-operation: abort immediately to the reset values. The pending result is discarded.

Optional Feature:
MD_FLUSH_EN:
- Defined:
  - flush port exists.
  - flush=1 in MUL/DIV: return to IDLE next edge, busy<=0, hi/lo untouched (pending discarded).
  - flush=1 with start=1 in IDLE: the op is suppressed, including mthi/mtlo.
  - flush has priority over completion in the same cycle; the result is dropped.
- Undefined: no flush port. Every started mult/div always completes.

Test Plan:
- Reset then idle → busy=0, hi=0, lo=0. Assert reset mid-DIV at count=4 → busy=0, hi=lo=0 asynchronously.
- mult, src_a=0xFFFFFFFF, src_b=0x00000002 → busy 5 cycles → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu, same operands → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div, src_a=0xFFFFFFF9 (-7), src_b=2 → busy 10 cycles → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 7/0 → hi/lo unchanged after 10 cycles.
- mthi 0x12345678, next cycle mtlo 0x9ABCDEF0 → hi/lo updated on the respective edges, busy never rises. Then div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MD_FLUSH_EN: mult 3×4, flush at busy cycle 2 → busy=0 next edge, hi/lo keep prior values. Flush coincident with the final count → result dropped.
